intc_cp0: RTL and testbench
===========================

Name: intc_cp0

Overview:
- Parametrised interrupt/exception controller: the coprocessor-0 unit for the multi-cycle CPU.
- Generalises the CPU's single interrupt input with a fixed cause to NUM_IRQ maskable sources, with per-channel edge/level mode and fixed priority.
- Also handles syscall traps and provides STATUS/CAUSE/EPC register access (mfc0/mtc0) and eret.
- The CPU samples int_req at its fetch stage and pulses int_ack when it redirects PC to int_vector.

Parameters:
- NUM_IRQ, 8, number of external interrupt sources (1..16).
- VECTOR, 32'h00000100, handler address presented on int_vector.
- SYS_CODE, 8, CAUSE value for a syscall.
- IRQ_CODE_BASE, 32, CAUSE value for channel k is IRQ_CODE_BASE+k.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  NUM_IRQ  raw asynchronous interrupt sources.
- syscall  in  1  one-cycle pulse from the EX stage.
- eret  in  1  one-cycle pulse from the EX stage.
- fetch_pc  in  32  PC of the next instruction to fetch; captured into EPC on ack.
- int_ack  in  1  CPU accepts the request (one cycle).
- int_req  out  1  interrupt/exception request to the CPU.
- int_vector  out  32  constant VECTOR.
- epc  out  32  current EPC, used by the CPU on eret.
- cp_addr  in  5  register select: 12 STATUS, 13 CAUSE, 14 EPC, 15 MASK, 16 MODE, 17 PENDING.
- cp_we  in  1  mtc0 write strobe.
- cp_wdata  in  32  write data.
- cp_rdata  out  32  combinational read of cp_addr; unmapped addresses read 0.

Behaviour:
- Reset values: STATUS, CAUSE, EPC, MASK, MODE and PENDING all 0. int_req=0. FSM=IDLE. Synchronisers 0.
- STATUS: bit0 IE (global enable), bit1 PIE (saved IE). Other bits read 0.
- MODE[k]: 1 = rising-edge, 0 = level.
- Synchronisation: each irq_in bit passes a 2-flop synchroniser (s1, s2) plus a history flop s3.
- Pending update at each edge:
  - Edge mode: PENDING[k] sets when s2&~s3. It is sticky.
  - Level mode: PENDING[k] = s2.
- Latency: irq_in high before edge 0 gives PENDING at edge 2 and int_req high after edge 3.
- PENDING writes are W1C, edge channels only. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Syscall: the pulse sets a sticky sys_pend flag. sys_pend clears on ack of a syscall request.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE → REQ when IE=1 and (sys_pend or |(PENDING&MASK)). The cause is latched in the same transition.
  - Priority: syscall first, then the lowest channel index.
  - REQ: int_req=1, held until int_ack even if MASK/IE/PENDING change meanwhile; the latched cause is unchanged.
  - REQ, on int_ack: EPC<=fetch_pc, CAUSE<=latched code, PIE<=IE, IE<=0. Clear the serviced PENDING bit if the channel is edge mode, or sys_pend if syscall. → SERVICE, and int_req falls the next cycle.
  - SERVICE: no new requests are raised. On eret: IE<=PIE → IDLE. A new request may be raised the cycle after.
- eret in IDLE or REQ: IE<=PIE, no state change.
- int_ack outside REQ is ignored.
- Write priority on the same cycle: ack/eret update of STATUS[1:0] beats a cp_we to STATUS. An ack EPC capture beats a cp_we to EPC.
- CAUSE is read-only to software.
- Events during SERVICE: a syscall pulse still sets sys_pend, and new edges still set PENDING; both are serviced after eret.
- Reset is asynchronous mid-operation: int_req drops immediately and all state clears.
- MASK/MODE/PENDING are NUM_IRQ bits wide, zero-extended on read. Writes ignore bits ≥ NUM_IRQ.

Test Plan:
1. Reset then IE=1, MASK=0x01, MODE=0x01; pulse irq_in[0] for 1 cycle → int_req high 4 edges later. Ack with fetch_pc=0x40 → EPC=0x40, CAUSE=32, STATUS=0x2, PENDING[0]=0.
2. Channels 2 and 5 pending (level), both masked in, IE=1 → CAUSE=34 (channel 2 wins). After eret with channel 2 still high → request again with CAUSE=34.
3. syscall pulse coincident with PENDING[1] set → CAUSE=8 first. After eret → CAUSE=33.
4. IE=0 with pending masked-in irq → int_req stays 0. Write STATUS=1 → int_req high 2 edges later. Clear MASK while in REQ → int_req still held until ack.
5. During SERVICE, edge irq3 fires → no request. eret → IE restored, int_req asserts the following cycle with CAUSE=35.
6. Assert rst asynchronously while in REQ → int_req falls without a clock edge. All registers read 0 afterward.

Source files
------------

// File: rtl/intc_cp0.sv
// intc_cp0 - coprocessor-0 interrupt/exception controller.
//
// Collects NUM_IRQ external interrupt sources (each 2-flop synchronised,
// per-channel edge or level mode, maskable) and syscall traps. It presents a
// single request to the CPU, latches the cause while the request is
// outstanding, and provides the STATUS/CAUSE/EPC/MASK/MODE/PENDING registers
// for mfc0/mtc0.
//
// Ports:
//   clk, rst          CPU clock, asynchronous active-high reset
//   irq_in            raw asynchronous interrupt sources
//   syscall, eret     one-cycle pulses from the EX stage
//   fetch_pc          PC of the next fetch; captured into EPC on ack
//   int_ack           CPU accepts the request (one cycle)
//   int_req           request to the CPU (high while in REQ)
//   int_vector        handler address (constant VECTOR)
//   epc               current EPC for eret
//   cp_addr/cp_we/cp_wdata/cp_rdata  coprocessor register access
module intc_cp0 #(
    parameter int unsigned NUM_IRQ       = 8,
    parameter logic [31:0] VECTOR        = 32'h0000_0100,
    parameter int unsigned SYS_CODE      = 8,
    parameter int unsigned IRQ_CODE_BASE = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               syscall,
    input  logic               eret,
    input  logic [31:0]        fetch_pc,
    input  logic               int_ack,
    output logic               int_req,
    output logic [31:0]        int_vector,
    output logic [31:0]        epc,
    input  logic [4:0]         cp_addr,
    input  logic               cp_we,
    input  logic [31:0]        cp_wdata,
    output logic [31:0]        cp_rdata
);

    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_MASK    = 5'd15;
    localparam logic [4:0] ADDR_MODE    = 5'd16;
    localparam logic [4:0] ADDR_PENDING = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic               ie_q, ie_d, pie_q, pie_d;
    logic [31:0]        cause_q, cause_d;
    logic [31:0]        epc_q, epc_d;
    logic               sys_pend_q, sys_pend_d;
    logic [31:0]        lat_code_q, lat_code_d;
    logic [4:0]         lat_chan_q, lat_chan_d;
    logic               lat_sys_q, lat_sys_d;

    logic [NUM_IRQ-1:0] rise_s, active_s, w1c_s, svc_clr_s;
    logic [4:0]         first_s;
    logic               ack_fire_s;

    // Lowest set index wins; scanning downwards leaves the lowest one last.
    function automatic logic [4:0] first_idx(input logic [NUM_IRQ-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
            if (v[k]) begin
                idx = 5'(k);
            end
        end
        return idx;
    endfunction

    assign rise_s     = s2_q & ~s3_q;
    assign active_s   = pending_q & mask_q;
    assign first_s    = first_idx(active_s);
    assign ack_fire_s = (state_q == ST_REQ) && int_ack;
    assign int_req    = (state_q == ST_REQ);
    assign int_vector = VECTOR;
    assign epc        = epc_q;

    // Request FSM: latch the cause on IDLE->REQ and hold it until ack.
    always_comb begin
        state_d    = state_q;
        lat_code_d = lat_code_q;
        lat_chan_d = lat_chan_q;
        lat_sys_d  = lat_sys_q;
        case (state_q)
            ST_IDLE: begin
                if (ie_q && (sys_pend_q || (|active_s))) begin
                    state_d = ST_REQ;
                    if (sys_pend_q) begin
                        lat_sys_d  = 1'b1;
                        lat_chan_d = 5'd0;
                        lat_code_d = 32'(SYS_CODE);
                    end else begin
                        lat_sys_d  = 1'b0;
                        lat_chan_d = first_s;
                        lat_code_d = 32'(IRQ_CODE_BASE) + 32'(first_s);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d = ST_SERVICE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register next-state: hardware updates (ack/eret) take priority over mtc0.
    always_comb begin
        ie_d       = ie_q;
        pie_d      = pie_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        mask_d     = mask_q;
        mode_d     = mode_q;
        w1c_s      = {NUM_IRQ{1'b0}};
        svc_clr_s  = {NUM_IRQ{1'b0}};

        if (ack_fire_s) begin
            pie_d = ie_q;
            ie_d  = 1'b0;
        end else if (eret) begin
            ie_d = pie_q;
        end else if (cp_we && (cp_addr == ADDR_STATUS)) begin
            ie_d  = cp_wdata[0];
            pie_d = cp_wdata[1];
        end else begin
            ie_d = ie_q;
        end

        if (ack_fire_s) begin
            epc_d   = fetch_pc;
            cause_d = lat_code_q;
        end else if (cp_we && (cp_addr == ADDR_EPC)) begin
            epc_d = cp_wdata;
        end else begin
            epc_d = epc_q;
        end

        if (cp_we && (cp_addr == ADDR_MASK)) begin
            mask_d = cp_wdata[NUM_IRQ-1:0];
        end else begin
            mask_d = mask_q;
        end

        if (cp_we && (cp_addr == ADDR_MODE)) begin
            mode_d = cp_wdata[NUM_IRQ-1:0];
        end else begin
            mode_d = mode_q;
        end

        if (cp_we && (cp_addr == ADDR_PENDING)) begin
            w1c_s = cp_wdata[NUM_IRQ-1:0];
        end else begin
            w1c_s = {NUM_IRQ{1'b0}};
        end

        for (int k = 0; k < int'(NUM_IRQ); k++) begin
            svc_clr_s[k] = ack_fire_s && !lat_sys_q && (lat_chan_q == 5'(k));
        end

        // Edge channels: sticky, clears lose to a same-cycle rising edge.
        // Level channels simply follow the synchronised input.
        pending_d = (mode_q & ((pending_q & ~(w1c_s | svc_clr_s)) | rise_s))
                  | (~mode_q & s2_q);

        sys_pend_d = syscall | (sys_pend_q & ~(ack_fire_s & lat_sys_q));
    end

    // Combinational coprocessor read mux; NUM_IRQ-wide registers zero-extend.
    always_comb begin
        cp_rdata = 32'd0;
        case (cp_addr)
            ADDR_STATUS:  cp_rdata = {30'd0, pie_q, ie_q};
            ADDR_CAUSE:   cp_rdata = cause_q;
            ADDR_EPC:     cp_rdata = epc_q;
            ADDR_MASK:    cp_rdata = 32'(mask_q);
            ADDR_MODE:    cp_rdata = 32'(mode_q);
            ADDR_PENDING: cp_rdata = 32'(pending_q);
            default:      cp_rdata = 32'd0;
        endcase
    end

    // State and register update with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s1_q       <= {NUM_IRQ{1'b0}};
            s2_q       <= {NUM_IRQ{1'b0}};
            s3_q       <= {NUM_IRQ{1'b0}};
            pending_q  <= {NUM_IRQ{1'b0}};
            mask_q     <= {NUM_IRQ{1'b0}};
            mode_q     <= {NUM_IRQ{1'b0}};
            ie_q       <= 1'b0;
            pie_q      <= 1'b0;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            sys_pend_q <= 1'b0;
            lat_code_q <= 32'd0;
            lat_chan_q <= 5'd0;
            lat_sys_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= irq_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            ie_q       <= ie_d;
            pie_q      <= pie_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            sys_pend_q <= sys_pend_d;
            lat_code_q <= lat_code_d;
            lat_chan_q <= lat_chan_d;
            lat_sys_q  <= lat_sys_d;
        end
    end

endmodule

// File: tb/tb_intc_cp0.sv
// Self-checking bench for intc_cp0: a register-access vector table followed
// by hand-written sequences for request latency, priority, masking, service
// nesting and asynchronous reset.
module tb_intc_cp0;

    localparam int unsigned NIRQ = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NIRQ-1:0] irq_in = 8'h00;
    logic            syscall = 1'b0;
    logic            eret = 1'b0;
    logic [31:0]     fetch_pc = 32'd0;
    logic            int_ack = 1'b0;
    logic            int_req;
    logic [31:0]     int_vector;
    logic [31:0]     epc;
    logic [4:0]      cp_addr = 5'd0;
    logic            cp_we = 1'b0;
    logic [31:0]     cp_wdata = 32'd0;
    logic [31:0]     cp_rdata;

    int total = 0;
    int bad   = 0;

    intc_cp0 #(
        .NUM_IRQ      (NIRQ),
        .VECTOR       (32'h0000_0100),
        .SYS_CODE     (8),
        .IRQ_CODE_BASE(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .syscall   (syscall),
        .eret      (eret),
        .fetch_pc  (fetch_pc),
        .int_ack   (int_ack),
        .int_req   (int_req),
        .int_vector(int_vector),
        .epc       (epc),
        .cp_addr   (cp_addr),
        .cp_we     (cp_we),
        .cp_wdata  (cp_wdata),
        .cp_rdata  (cp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cp_addr  = a;
        cp_wdata = d;
        cp_we    = 1'b1;
        tick();
        cp_we    = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        cp_addr = a;
        #1;
        check(name, cp_rdata, exp);
    endtask

    task automatic ack(input logic [31:0] pc);
        fetch_pc = pc;
        int_ack  = 1'b1;
        tick();
        int_ack  = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic wait_req(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int_req) break;
            tick();
        end
        check(name, {31'd0, int_req}, 32'd1);
    endtask

    task automatic rd_all_zero(input string tag);
        rd({tag, "_status"},  5'd12, 32'd0);
        rd({tag, "_cause"},   5'd13, 32'd0);
        rd({tag, "_epc"},     5'd14, 32'd0);
        rd({tag, "_mask"},    5'd15, 32'd0);
        rd({tag, "_mode"},    5'd16, 32'd0);
        rd({tag, "_pending"}, 5'd17, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[1]  = '{1'b1, 5'd12, 32'hFFFF_FFF0, 32'h0000_0000};
        vecs[2]  = '{1'b1, 5'd15, 32'hFFFF_FF5A, 32'h0000_005A};
        vecs[3]  = '{1'b1, 5'd16, 32'h0000_1234, 32'h0000_0034};
        vecs[4]  = '{1'b1, 5'd14, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 5'd13, 32'h0000_0055, 32'h0000_0000};
        vecs[6]  = '{1'b1, 5'd5,  32'h0000_0077, 32'h0000_0000};
        vecs[7]  = '{1'b0, 5'd18, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{1'b1, 5'd17, 32'h0000_00FF, 32'h0000_0000};
        vecs[9]  = '{1'b1, 5'd15, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b1, 5'd16, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{1'b1, 5'd14, 32'h0000_0000, 32'h0000_0000};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_int_req", {31'd0, int_req}, 32'd0);
        check("int_vector", int_vector, 32'h0000_0100);
        rd_all_zero("reset");

        // Register access table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // 1: edge channel 0, exact latency, ack captures EPC/CAUSE/STATUS
        wr(5'd12, 32'd1);
        wr(5'd15, 32'h01);
        wr(5'd16, 32'h01);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        check("t1_req_e0", {31'd0, int_req}, 32'd0);
        tick();
        check("t1_req_e1", {31'd0, int_req}, 32'd0);
        tick();
        check("t1_req_e2", {31'd0, int_req}, 32'd0);
        rd("t1_pend_e2", 5'd17, 32'h01);
        tick();
        check("t1_req_e3", {31'd0, int_req}, 32'd1);
        ack(32'h40);
        check("t1_req_after_ack", {31'd0, int_req}, 32'd0);
        check("t1_epc_port", epc, 32'h40);
        rd("t1_epc", 5'd14, 32'h40);
        rd("t1_cause", 5'd13, 32'd32);
        rd("t1_status", 5'd12, 32'h2);
        rd("t1_pending", 5'd17, 32'h0);
        do_eret();
        rd("t1_status_eret", 5'd12, 32'h3);
        tick();
        check("t1_no_req", {31'd0, int_req}, 32'd0);

        // 2: level channels 2 and 5, lowest index wins, re-request after eret
        wr(5'd16, 32'h00);
        wr(5'd15, 32'h24);
        irq_in[2] = 1'b1;
        irq_in[5] = 1'b1;
        wait_req("t2_req", 10);
        ack(32'h80);
        rd("t2_cause", 5'd13, 32'd34);
        rd("t2_epc", 5'd14, 32'h80);
        do_eret();
        check("t2_req_eret_cycle", {31'd0, int_req}, 32'd0);
        tick();
        check("t2_rereq", {31'd0, int_req}, 32'd1);
        ack(32'h84);
        rd("t2_cause2", 5'd13, 32'd34);
        irq_in[2] = 1'b0;
        irq_in[5] = 1'b0;
        repeat (5) tick();
        do_eret();
        tick(); tick();
        check("t2_quiet", {31'd0, int_req}, 32'd0);

        // 3: syscall and edge channel 1 together, syscall first
        wr(5'd12, 32'd0);
        wr(5'd16, 32'h02);
        wr(5'd15, 32'h02);
        irq_in[1] = 1'b1;
        tick(); tick();
        syscall = 1'b1;
        tick();
        syscall = 1'b0;
        rd("t3_pend", 5'd17, 32'h02);
        tick();
        check("t3_ie0_no_req", {31'd0, int_req}, 32'd0);
        wr(5'd12, 32'd1);
        tick();
        check("t3_req", {31'd0, int_req}, 32'd1);
        ack(32'h100);
        rd("t3_cause_sys", 5'd13, 32'd8);
        rd("t3_status", 5'd12, 32'h2);
        rd("t3_pend_kept", 5'd17, 32'h02);
        do_eret();
        tick();
        check("t3_req2", {31'd0, int_req}, 32'd1);
        ack(32'h104);
        rd("t3_cause_irq1", 5'd13, 32'd33);
        rd("t3_pend_clr", 5'd17, 32'h00);
        irq_in[1] = 1'b0;
        do_eret();
        tick();
        check("t3_quiet", {31'd0, int_req}, 32'd0);

        // 4: IE gating, request held while MASK is cleared
        wr(5'd12, 32'd0);
        wr(5'd16, 32'h00);
        wr(5'd15, 32'h10);
        irq_in[4] = 1'b1;
        repeat (5) tick();
        check("t4_ie0", {31'd0, int_req}, 32'd0);
        wr(5'd12, 32'd1);
        check("t4_req_edge1", {31'd0, int_req}, 32'd0);
        tick();
        check("t4_req_edge2", {31'd0, int_req}, 32'd1);
        wr(5'd15, 32'h00);
        tick(); tick();
        check("t4_held", {31'd0, int_req}, 32'd1);
        ack(32'h200);
        rd("t4_cause", 5'd13, 32'd36);
        check("t4_req_drop", {31'd0, int_req}, 32'd0);
        irq_in[4] = 1'b0;

        // 5: edge during SERVICE waits for eret; ack EPC beats mtc0 EPC
        wr(5'd16, 32'h08);
        wr(5'd15, 32'h08);
        irq_in[3] = 1'b1;
        tick();
        irq_in[3] = 1'b0;
        repeat (5) tick();
        check("t5_no_req_service", {31'd0, int_req}, 32'd0);
        rd("t5_pend", 5'd17, 32'h08);
        rd("t5_status_svc", 5'd12, 32'h2);
        do_eret();
        rd("t5_status_eret", 5'd12, 32'h3);
        check("t5_req_eret_cycle", {31'd0, int_req}, 32'd0);
        tick();
        check("t5_req", {31'd0, int_req}, 32'd1);
        cp_addr  = 5'd14;
        cp_wdata = 32'h1234;
        cp_we    = 1'b1;
        ack(32'hC0);
        cp_we    = 1'b0;
        rd("t5_epc_prio", 5'd14, 32'hC0);
        rd("t5_cause", 5'd13, 32'd35);
        rd("t5_pend_clr", 5'd17, 32'h00);

        // 6: asynchronous reset while requesting
        do_eret();
        irq_in[3] = 1'b1;
        tick();
        irq_in[3] = 1'b0;
        wait_req("t6_req", 10);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_req", {31'd0, int_req}, 32'd0);
        check("t6_async_epc", epc, 32'd0);
        tick();
        rst = 1'b0;
        rd_all_zero("t6");

        // W1C clears an edge bit; a same-cycle rising edge wins over W1C
        wr(5'd16, 32'h01);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        repeat (3) tick();
        rd("w1c_before", 5'd17, 32'h01);
        wr(5'd17, 32'h01);
        rd("w1c_after", 5'd17, 32'h00);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        tick();
        wr(5'd17, 32'h01);
        rd("set_beats_w1c", 5'd17, 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
